// File: rtl/ecualizador_pkg.sv
// -----------------------------------------------------------------------------
// ecualizador_pkg
// Shared types and constants for the equaliser signal chain.
//   - estado_t        : biquad sequencer states (IDLE, MAC, OUT)
//   - COEF_W/FRAC     : sample/coefficient width and Q2.13 fraction bits
//   - ACC_W/PROD_W    : accumulator and product widths
//   - redondear_saturar : round-half-up, shift by FRAC, clamp to 16 bits
// -----------------------------------------------------------------------------
package ecualizador_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } estado_t;

    localparam int COEF_W = 16;
    localparam int FRAC   = 13;
    localparam int ACC_W  = 35;
    localparam int PROD_W = 2 * COEF_W;
    localparam int SHR_W  = ACC_W - FRAC;

    // Index of the last product term (B0, B1, B2, A1, A2 -> 0..4)
    localparam logic [2:0] K_LAST = 3'd4;

    // Half an LSB of the output before the shift: round half up
    localparam logic signed [ACC_W-1:0] REDONDEO = 35'sd4096;

    localparam logic signed [SHR_W-1:0] SAT_MAX = 22'sd32767;
    localparam logic signed [SHR_W-1:0] SAT_MIN = -22'sd32768;

    // Round the accumulator, drop the fraction bits and clamp to 16 bits.
    // Taking the upper slice of the rounded sum is the arithmetic shift.
    function automatic logic signed [COEF_W-1:0] redondear_saturar(
        input logic signed [ACC_W-1:0] acc
    );
        logic signed [ACC_W-1:0]  suma;
        logic signed [SHR_W-1:0]  desp;
        logic signed [COEF_W-1:0] res;
        suma = acc + REDONDEO;
        desp = suma[ACC_W-1:FRAC];
        if (desp > SAT_MAX) begin
            res = SAT_MAX[COEF_W-1:0];
        end else if (desp < SAT_MIN) begin
            res = SAT_MIN[COEF_W-1:0];
        end else begin
            res = desp[COEF_W-1:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/sync_flanco.sv
// -----------------------------------------------------------------------------
// sync_flanco
// Brings the ADC receiver's `listo` level into the system clock domain and
// produces a one-cycle pulse on each rising edge of the synchronised level.
// Ports:
//   clk    in  system clock
//   reset  in  asynchronous, active-high; clears all three flops
//   d      in  asynchronous level to synchronise
//   flanco out one-cycle rising-edge pulse of the synchronised level
// -----------------------------------------------------------------------------
module sync_flanco (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic flanco
);

    logic meta_r;
    logic sync_r;
    logic prev_r;

    // Two-stage synchroniser plus the history flop for edge detection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_r <= 1'b0;
            sync_r <= 1'b0;
            prev_r <= 1'b0;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
            prev_r <= sync_r;
        end
    end

    // Both operands are flops, so the pulse is glitch-free and one clk wide
    assign flanco = sync_r & ~prev_r;

endmodule

// File: rtl/biquad_filtro.sv
// -----------------------------------------------------------------------------
// biquad_filtro
// Second-order IIR stage between the ADC receiver and the equaliser mixer.
//   y[n] = (B0*x[n] + B1*x[n-1] + B2*x[n-2] - A1*y[n-1] - A2*y[n-2]) >> 13
// One shared multiplier evaluates the five terms over five MAC cycles; the
// result is rounded half up, saturated to 16 bits and fed back as y[n-1].
// Parameters: B0, B1, B2, A1, A2 -- signed Q2.13 coefficients.
// Ports:
//   clk      in  system clock
//   reset    in  asynchronous, active-high
//   d_in     in  16-bit signed sample, stable while listo is high
//   listo    in  sample-ready level from the ADC receiver (other clock domain)
//   y_out    out filtered sample, held until the next result
//   y_valid  out one-cycle strobe when y_out is updated
//   busy     out high from capture through the y_valid cycle
//   overrun  out sticky; a sample edge arrived while a computation was running
// -----------------------------------------------------------------------------
module biquad_filtro
    import ecualizador_pkg::*;
#(
    parameter logic signed [COEF_W-1:0] B0 = 16'sh2000,
    parameter logic signed [COEF_W-1:0] B1 = 16'sh0000,
    parameter logic signed [COEF_W-1:0] B2 = 16'sh0000,
    parameter logic signed [COEF_W-1:0] A1 = 16'sh0000,
    parameter logic signed [COEF_W-1:0] A2 = 16'sh0000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic signed [COEF_W-1:0] d_in,
    input  logic                     listo,
    output logic signed [COEF_W-1:0] y_out,
    output logic                     y_valid,
    output logic                     busy,
    output logic                     overrun
);

    estado_t                  state_r;
    estado_t                  state_s;
    logic                     flanco_s;
    logic [2:0]               k_r;

    logic signed [COEF_W-1:0] x0_r;
    logic signed [COEF_W-1:0] x1_r;
    logic signed [COEF_W-1:0] x2_r;
    logic signed [COEF_W-1:0] y1_r;
    logic signed [COEF_W-1:0] y2_r;
    logic signed [ACC_W-1:0]  acc_r;

    logic signed [COEF_W-1:0] coef_s;
    logic signed [COEF_W-1:0] oper_s;
    logic                     resta_s;
    logic signed [PROD_W-1:0] prod_s;
    logic signed [ACC_W-1:0]  prod_ext_s;
    logic signed [COEF_W-1:0] y_sat_s;

    logic signed [COEF_W-1:0] y_out_r;
    logic                     y_valid_r;
    logic                     busy_r;
    logic                     overrun_r;

    sync_flanco u_sync (
        .clk    (clk),
        .reset  (reset),
        .d      (listo),
        .flanco (flanco_s)
    );

    // Operand selection for the shared multiplier; feedback terms subtract
    always_comb begin
        coef_s  = 16'sh0000;
        oper_s  = 16'sh0000;
        resta_s = 1'b0;
        case (k_r)
            3'd0: begin
                coef_s = B0;
                oper_s = x0_r;
            end
            3'd1: begin
                coef_s = B1;
                oper_s = x1_r;
            end
            3'd2: begin
                coef_s = B2;
                oper_s = x2_r;
            end
            3'd3: begin
                coef_s  = A1;
                oper_s  = y1_r;
                resta_s = 1'b1;
            end
            3'd4: begin
                coef_s  = A2;
                oper_s  = y2_r;
                resta_s = 1'b1;
            end
            default: begin
                coef_s  = 16'sh0000;
                oper_s  = 16'sh0000;
                resta_s = 1'b0;
            end
        endcase
    end

    assign prod_s     = coef_s * oper_s;
    assign prod_ext_s = {{(ACC_W-PROD_W){prod_s[PROD_W-1]}}, prod_s};
    assign y_sat_s    = redondear_saturar(acc_r);

    // Sequencer next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (flanco_s) begin
                    state_s = MAC;
                end else begin
                    state_s = IDLE;
                end
            end
            MAC: begin
                if (k_r == K_LAST) begin
                    state_s = OUT;
                end else begin
                    state_s = MAC;
                end
            end
            OUT: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Sequencer state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Capture, multiply-accumulate, output register and history shift
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            k_r       <= 3'd0;
            x0_r      <= 16'sh0000;
            x1_r      <= 16'sh0000;
            x2_r      <= 16'sh0000;
            y1_r      <= 16'sh0000;
            y2_r      <= 16'sh0000;
            acc_r     <= {ACC_W{1'b0}};
            y_out_r   <= 16'sh0000;
            y_valid_r <= 1'b0;
        end else begin
            y_valid_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (flanco_s) begin
                        x0_r  <= d_in;
                        acc_r <= {ACC_W{1'b0}};
                        k_r   <= 3'd0;
                    end
                end
                MAC: begin
                    if (resta_s) begin
                        acc_r <= acc_r - prod_ext_s;
                    end else begin
                        acc_r <= acc_r + prod_ext_s;
                    end
                    k_r <= k_r + 3'd1;
                end
                OUT: begin
                    y_out_r   <= y_sat_s;
                    y_valid_r <= 1'b1;
                    x2_r      <= x1_r;
                    x1_r      <= x0_r;
                    y2_r      <= y1_r;
                    // The clamped value, not the raw sum, is what feeds back
                    y1_r      <= y_sat_s;
                end
                default: begin
                    k_r <= 3'd0;
                end
            endcase
        end
    end

    // Status flags: busy spans capture through the y_valid cycle;
    // an edge seen outside IDLE is dropped and latches overrun
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_r    <= 1'b0;
            overrun_r <= 1'b0;
        end else begin
            busy_r <= (state_s != IDLE) || (state_r == OUT);
            if (flanco_s && (state_r != IDLE)) begin
                overrun_r <= 1'b1;
            end
        end
    end

    assign y_out   = y_out_r;
    assign y_valid = y_valid_r;
    assign busy    = busy_r;
    assign overrun = overrun_r;

endmodule

// File: tb/tb_biquad_filtro.sv
// -----------------------------------------------------------------------------
// tb_biquad_filtro
// Four filter instances (passthrough, feedback, saturating, all-terms) share
// one stimulus. A behavioural model predicts, per clock, each instance's
// y_valid, y_out, busy and overrun from the listo/reset history and plain
// integer arithmetic of the difference equation. Literal expectations pin
// the model on the directed sequences.
// -----------------------------------------------------------------------------
module tb_biquad_filtro;

    logic               clk   = 1'b0;
    logic               reset = 1'b1;
    logic               listo = 1'b0;
    logic signed [15:0] d_in  = 16'sd0;

    logic signed [15:0] y_out   [4];
    logic               y_valid [4];
    logic               busy    [4];
    logic               overrun [4];

    always #10 clk = ~clk;

    biquad_filtro u_pass (
        .clk(clk), .reset(reset), .d_in(d_in), .listo(listo),
        .y_out(y_out[0]), .y_valid(y_valid[0]), .busy(busy[0]), .overrun(overrun[0])
    );

    biquad_filtro #(.A1(16'shF000)) u_fb (
        .clk(clk), .reset(reset), .d_in(d_in), .listo(listo),
        .y_out(y_out[1]), .y_valid(y_valid[1]), .busy(busy[1]), .overrun(overrun[1])
    );

    biquad_filtro #(.B0(16'sh7FFF)) u_sat (
        .clk(clk), .reset(reset), .d_in(d_in), .listo(listo),
        .y_out(y_out[2]), .y_valid(y_valid[2]), .busy(busy[2]), .overrun(overrun[2])
    );

    biquad_filtro #(.B0(16'sh1000), .B1(16'sh0800), .B2(16'shFC00),
                    .A1(16'shE000), .A2(16'sh1000)) u_full (
        .clk(clk), .reset(reset), .d_in(d_in), .listo(listo),
        .y_out(y_out[3]), .y_valid(y_valid[3]), .busy(busy[3]), .overrun(overrun[3])
    );

    int tests = 0;
    int fails = 0;

    // Coefficients of each instance as plain integers (Q2.13)
    longint cb0 [4] = '{8192, 8192, 32767, 4096};
    longint cb1 [4] = '{0, 0, 0, 2048};
    longint cb2 [4] = '{0, 0, 0, -1024};
    longint ca1 [4] = '{0, -4096, 0, -8192};
    longint ca2 [4] = '{0, 0, 0, 4096};

    // Model state
    int     cyc      = 0;
    bit     prev_l   = 1'b0;
    int     cap_q [$];
    int     free_at  = 0;
    int     valid_at = -1;
    int     busy_lo  = -1;
    int     busy_hi  = -2;
    bit     ovr      = 1'b0;
    longint xh1 [4];
    longint xh2 [4];
    longint yh1 [4];
    longint yh2 [4];
    longint pend [4];
    longint exp_y [4];
    int     lit_q0 [$];
    int     lit_q1 [$];
    int     lit_q2 [$];
    int     nvalid = 0;

    task automatic cmp(input string name, input int inst, input longint act, input longint expv);
        tests++;
        if (act != expv) begin
            fails++;
            $display("FAIL %s[%0d] cycle %0d: got %0d, expected %0d", name, inst, cyc, act, expv);
        end
    endtask

    // Difference equation on integers, then update that instance's history
    task automatic filt(input int i, input longint x, output longint r);
        longint s;
        s = cb0[i] * x + cb1[i] * xh1[i] + cb2[i] * xh2[i] - ca1[i] * yh1[i] - ca2[i] * yh2[i];
        r = (s + 64'sd4096) >>> 13;
        if (r > 32767) r = 32767;
        else if (r < -32768) r = -32768;
        xh2[i] = xh1[i];
        xh1[i] = x;
        yh2[i] = yh1[i];
        yh1[i] = r;
    endtask

    task automatic pin(input int i, input int lit);
        cmp("model_literal", i, exp_y[i], lit);
        cmp("dut_literal", i, y_out[i], lit);
    endtask

    // Advance the model by the clock edge just past and compare every output
    task automatic step();
        longint r;
        cyc++;
        if (reset) begin
            prev_l   = 1'b0;
            cap_q.delete();
            free_at  = 0;
            valid_at = -1;
            busy_lo  = -1;
            busy_hi  = -2;
            ovr      = 1'b0;
            lit_q0.delete();
            lit_q1.delete();
            lit_q2.delete();
            for (int i = 0; i < 4; i++) begin
                xh1[i] = 0; xh2[i] = 0; yh1[i] = 0; yh2[i] = 0;
                pend[i] = 0; exp_y[i] = 0;
            end
        end else begin
            // A rising listo sample is acted on two edges later
            if (listo && !prev_l) cap_q.push_back(cyc + 2);
            prev_l = listo;
            if (cap_q.size() > 0 && cap_q[0] == cyc) begin
                void'(cap_q.pop_front());
                if (cyc >= free_at) begin
                    for (int i = 0; i < 4; i++) begin
                        filt(i, longint'(d_in), r);
                        pend[i] = r;
                    end
                    valid_at = cyc + 6;
                    free_at  = cyc + 7;
                    busy_lo  = cyc;
                    busy_hi  = cyc + 6;
                end else begin
                    ovr = 1'b1;
                end
            end
            if (cyc == valid_at) begin
                for (int i = 0; i < 4; i++) exp_y[i] = pend[i];
                if (lit_q0.size() > 0) pin(0, lit_q0.pop_front());
                if (lit_q1.size() > 0) pin(1, lit_q1.pop_front());
                if (lit_q2.size() > 0) pin(2, lit_q2.pop_front());
            end
        end
        for (int i = 0; i < 4; i++) begin
            cmp("y_valid", i, y_valid[i], (!reset && cyc == valid_at) ? 1 : 0);
            cmp("y_out", i, y_out[i], exp_y[i]);
            cmp("busy", i, busy[i], (!reset && cyc >= busy_lo && cyc <= busy_hi) ? 1 : 0);
            cmp("overrun", i, overrun[i], ovr ? 1 : 0);
        end
        if (y_valid[0]) nvalid++;
    endtask

    task automatic tick();
        @(negedge clk);
        step();
        #1;
    endtask

    task automatic send(input logic signed [15:0] x, input int hold, input int gap);
        d_in  = x;
        listo = 1'b1;
        repeat (hold) tick();
        listo = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
    endtask

    initial begin
        int n0;
        int hold;
        int gap;
        logic signed [15:0] x;

        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        repeat (3) tick();

        // Passthrough with default coefficients
        lit_q0.push_back(1000);  send(16'sd1000, 2, 12);
        lit_q0.push_back(-2048); send(-16'sd2048, 2, 12);
        lit_q0.push_back(2047);  send(16'sd2047, 2, 12);

        // Feedback impulse response, A1 = -0.5
        do_reset();
        lit_q1.push_back(1000); lit_q1.push_back(500); lit_q1.push_back(250);
        lit_q1.push_back(125);  lit_q1.push_back(63);
        lit_q0.push_back(1000); lit_q0.push_back(0); lit_q0.push_back(0);
        lit_q0.push_back(0);    lit_q0.push_back(0);
        send(16'sd1000, 2, 12);
        repeat (4) send(16'sd0, 2, 12);

        // Saturation at both rails
        do_reset();
        lit_q2.push_back(32767); lit_q2.push_back(-32768);
        lit_q0.push_back(32767); lit_q0.push_back(-32768);
        send(16'sd32767, 2, 12);
        send(-16'sd32768, 2, 12);

        // Reset in the middle of MAC aborts the computation
        d_in  = 16'sd777;
        listo = 1'b1;
        repeat (4) tick();
        reset = 1'b1;
        #1;
        cmp("abort_y_out", 0, y_out[0], 0);
        cmp("abort_busy", 0, busy[0], 0);
        cmp("abort_y_valid", 0, y_valid[0], 0);
        listo = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
        tick();
        lit_q0.push_back(500);
        send(16'sd500, 2, 12);

        // Second edge three clocks after the first is dropped
        n0    = nvalid;
        d_in  = 16'sd321;
        listo = 1'b1;
        tick();
        listo = 1'b0;
        repeat (2) tick();
        listo = 1'b1;
        repeat (2) tick();
        listo = 1'b0;
        repeat (15) tick();
        cmp("overrun_strobes", 0, nvalid - n0, 1);
        cmp("overrun_set", 0, overrun[0], 1);
        send(16'sd1200, 2, 12);
        cmp("overrun_sticky", 0, overrun[0], 1);

        // Level held high for 200 clocks gives a single capture
        do_reset();
        cmp("overrun_cleared", 0, overrun[0], 0);
        n0    = nvalid;
        d_in  = -16'sd1500;
        listo = 1'b1;
        repeat (200) tick();
        listo = 1'b0;
        repeat (12) tick();
        cmp("held_strobes", 0, nvalid - n0, 1);

        // Random samples and spacing, occasionally too close together
        do_reset();
        for (int n = 0; n < 150; n++) begin
            x    = 16'($urandom);
            hold = int'($urandom_range(1, 5));
            if ($urandom_range(0, 9) == 0) gap = int'($urandom_range(1, 3));
            else gap = int'($urandom_range(7, 20));
            send(x, hold, gap);
        end
        repeat (12) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
